// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared widths, FSM states and pipeline-stage record for the psum buffer
package psum_pkg;

    localparam int PSUM_WIDTH = 25;
    localparam int PSUM_DEPTH = 64;
    localparam int PSUM_AW    = $clog2(PSUM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One element in flight between the PE transfer and the tree output.
    typedef struct packed {
        logic               valid;
        logic [PSUM_AW-1:0] idx;
        logic               last_pass;
        logic               first_pass;
    } stage_t;

endpackage

// File: rtl/psum_buffer_mem.sv
// rtl/psum_buffer_mem.sv - 1R1W partial-sum array with registered read port, no reset
module psum_buffer_mem #(
    parameter int data_width = 25,
    parameter int depth      = 64,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] rd_data_q;

    // Storage write and registered read; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/psum_buffer.sv
// rtl/psum_buffer.sv - partial-sum buffer closing the accumulation loop around the psum adder tree
module psum_buffer
    import psum_pkg::*;
#(
    parameter int data_width = PSUM_WIDTH,
    parameter int depth      = PSUM_DEPTH,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width:0]   cfg_len,
    input  logic [7:0]            cfg_passes,
    output logic                  busy,
    output logic                  done,
    input  logic                  pe_valid,
    output logic                  pe_ready,
    output logic [data_width-1:0] fifo_data,
    input  logic [data_width-1:0] psum_in,
    output logic                  result_valid,
    output logic [data_width-1:0] result_data
);

    localparam logic [addr_width:0] LEN_MAX  = (addr_width + 1)'(depth);
    localparam logic [addr_width:0] ELEM_ONE = (addr_width + 1)'(1);

    state_t                state_q, state_d;
    logic [addr_width:0]   elem_cnt_q, elem_cnt_d;
    logic [addr_width:0]   len_q, len_d;
    logic [7:0]            pass_cnt_q, pass_cnt_d;
    logic [7:0]            passes_q, passes_d;
    stage_t                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [data_width-1:0] fifo_data_q, fifo_data_d;
    logic [data_width-1:0] result_data_q, result_data_d;
    logic                  result_valid_q, result_valid_d;

    logic                  rd_en, wr_en;
    logic [data_width-1:0] rd_data;
    logic                  xfer, is_last, is_first, len_ok;
    logic [addr_width:0]   elem_next;
    logic                  unused_s3_first;

    // Next-state logic: FSM, pass/element counters, element pipeline and output registers.
    always_comb begin
        state_d        = state_q;
        elem_cnt_d     = elem_cnt_q;
        len_d          = len_q;
        pass_cnt_d     = pass_cnt_q;
        passes_d       = passes_q;
        s1_d           = '0;
        s2_d           = s1_q;
        s3_d           = s2_q;
        fifo_data_d    = fifo_data_q;
        result_data_d  = result_data_q;
        result_valid_d = 1'b0;
        wr_en          = 1'b0;

        xfer      = (state_q == ST_ACCUM) && pe_valid;
        is_last   = (pass_cnt_q == passes_q - 8'd1);
        is_first  = (pass_cnt_q == 8'd0);
        len_ok    = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        elem_next = elem_cnt_q + ELEM_ONE;
        rd_en     = xfer;

        // The read for an element is launched on its transfer edge so the
        // registered read data is present while the element sits in stage 1.
        if (xfer) begin
            s1_d       = '{valid: 1'b1, idx: elem_cnt_q[addr_width-1:0],
                           last_pass: is_last, first_pass: is_first};
            elem_cnt_d = elem_next;
        end

        if (s1_q.valid) begin
            fifo_data_d = s1_q.first_pass ? '0 : rd_data;
        end

        if (s3_q.valid) begin
            if (s3_q.last_pass) begin
                result_data_d  = psum_in;
                result_valid_d = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && len_ok) begin
                    state_d    = ST_ACCUM;
                    len_d      = cfg_len;
                    passes_d   = (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
                    elem_cnt_d = '0;
                    pass_cnt_d = 8'd0;
                end
            end
            ST_ACCUM: begin
                if (xfer && (elem_next == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Between passes, re-open once stage 3 is the only occupant: its
                // write lands on this edge, before any read of the next pass.
                if (is_last) begin
                    if (!s1_q.valid && !s2_q.valid && !s3_q.valid) begin
                        state_d = ST_DONE;
                    end
                end else if (!s1_q.valid && !s2_q.valid) begin
                    state_d    = ST_ACCUM;
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    elem_cnt_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; memory contents are not part of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            elem_cnt_q     <= '0;
            len_q          <= '0;
            pass_cnt_q     <= 8'd0;
            passes_q       <= 8'd0;
            s1_q           <= '0;
            s2_q           <= '0;
            s3_q           <= '0;
            fifo_data_q    <= '0;
            result_data_q  <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            elem_cnt_q     <= elem_cnt_d;
            len_q          <= len_d;
            pass_cnt_q     <= pass_cnt_d;
            passes_q       <= passes_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            fifo_data_q    <= fifo_data_d;
            result_data_q  <= result_data_d;
            result_valid_q <= result_valid_d;
        end
    end

    psum_buffer_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (s3_q.idx),
        .wr_data (psum_in),
        .rd_en   (rd_en),
        .rd_addr (elem_cnt_q[addr_width-1:0]),
        .rd_data (rd_data)
    );

    assign unused_s3_first = s3_q.first_pass;

    assign busy         = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign pe_ready     = (state_q == ST_ACCUM);
    assign fifo_data    = fifo_data_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;

endmodule
